decode_alu7: RTL and testbench
==============================

// Module: decode_alu7
// PURPOSE
//  - ALU control decoder slice for the NLP-16a ALU; generates control line ALU7
//    (adder carry-in / shifter fill bit) from the 6-bit ALU control word and C flag.
//  - Also reports a decoded operation index and an illegal-code flag.
//  - Sits between the microcode control word and the ALU datapath; all outputs registered.
// PARAMETERS
//  - none
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  Ctrl0      in   1  control word bit 0 (1 = shift/rotate class)
//  Ctrl1      in   1  control word bit 1 (1 = arithmetic class when Ctrl0=0)
//  Ctrl2      in   1  control word bit 2
//  Ctrl3      in   1  control word bit 3
//  Ctrl4      in   1  control word bit 4
//  Ctrl5      in   1  control word bit 5
//  c_flag     in   1  current carry flag from flag register
//  ALU7_out   out  1  registered carry-in / shift-fill bit to ALU
//  op_idx     out  4  registered decoded operation index (table below), 15 = illegal
//  illegal    out  1  registered: 1 when control word matches no table entry
// BEHAVIOUR
//  - One clock, synchronous active-high reset; no asynchronous paths.
//  - Reset: ALU7_out=0, op_idx=4'd15, illegal=0; rst overrides inputs that cycle.
//  - Latency 1 cycle: outputs at edge N+1 reflect inputs sampled at edge N. No handshake.
//  - Word written {Ctrl0..Ctrl5}, Ctrl0 leftmost. Decode table (word: idx, ALU7):
//      MOV 000000: 0,0       AND 000110: 1,0       OR  001010: 2,0
//      NOT 001100: 3,0       XOR 001110: 4,0       ADD 010010: 5,0
//      SUB 010001: 6,1       INC 011011: 7,1       DEC 011000: 8,0
//      SLL 100000: 9,0       SLA 100100: 10,0      ROL 100010: 11,c_flag
//      SRL 101000: 12,0      SRA 101100: 13,0      ROR 101010: 14,c_flag
//  - SUB/INC: carry-in 1 (two's-complement subtract / +1). DEC: adds all-ones with cin 0.
//  - ROL/ROR rotate through carry: fill bit = c_flag sampled in the same cycle as the word.
//  - SRA sign replication is done in the datapath; ALU7 is 0 for SRA.
//  - Any of the other 49 words: op_idx=15, illegal=1, ALU7_out=0 (c_flag ignored).
//  - c_flag affects ALU7_out only for ROL/ROR; toggling it under any other word leaves
//    all outputs unchanged.
//  - Decode is purely a function of the current sample; no internal state beyond output regs.
//  - Reset released mid-stream: first post-reset edge registers the word then present.
// TESTING
//  - rst=1 two cycles with word 010001 -> ALU7_out=0, op_idx=15, illegal=0 while held.
//  - Sweep all 15 table words with c_flag=0 -> one cycle later idx/ALU7 per table
//    (ADD 5/0, SUB 6/1, INC 7/1, ROL 11/0), illegal=0.
//  - ROL 100010 and ROR 101010 with c_flag=1 -> ALU7_out=1; c_flag 1->0 -> ALU7_out=0
//    next cycle.
//  - MOV/ADD/SRA with c_flag toggling -> ALU7_out stays 0, op_idx stable (0/5/13).
//  - Illegal words 111111 and 010000 with c_flag=1 -> illegal=1, op_idx=15, ALU7_out=0.
//  - Assert rst during INC stream -> next edge outputs reset values; deassert -> INC
//    (7,1) reappears after one cycle.

Source files
------------

// File: rtl/decode_alu7.sv
// -----------------------------------------------------------------------------
// decode_alu7
//   ALU control decoder slice for the NLP-16a ALU. Decodes the 6-bit ALU
//   control word (Ctrl0 is the most significant / leftmost bit) together with
//   the carry flag into:
//     - ALU7_out : adder carry-in / shifter fill bit
//     - op_idx   : operation index (0..14), 15 for an unrecognised word
//     - illegal  : set when the word matches no operation
//   All outputs are registered with one cycle of latency. Synchronous reset.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous, active-high reset
//   Ctrl0..5  in   1  control word bits (Ctrl0 = shift/rotate class,
//                     Ctrl1 = arithmetic class when Ctrl0 = 0)
//   c_flag    in   1  current carry flag
//   ALU7_out  out  1  registered carry-in / shift-fill bit
//   op_idx    out  4  registered operation index, 15 = illegal
//   illegal   out  1  registered illegal-word flag
// -----------------------------------------------------------------------------
module decode_alu7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       Ctrl0,
    input  logic       Ctrl1,
    input  logic       Ctrl2,
    input  logic       Ctrl3,
    input  logic       Ctrl4,
    input  logic       Ctrl5,
    input  logic       c_flag,
    output logic       ALU7_out,
    output logic [3:0] op_idx,
    output logic       illegal
);

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_AND = 4'd1,
        OP_OR  = 4'd2,
        OP_NOT = 4'd3,
        OP_XOR = 4'd4,
        OP_ADD = 4'd5,
        OP_SUB = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SLL = 4'd9,
        OP_SLA = 4'd10,
        OP_ROL = 4'd11,
        OP_SRL = 4'd12,
        OP_SRA = 4'd13,
        OP_ROR = 4'd14,
        OP_ILL = 4'd15
    } op_e;

    logic [5:0] word;
    op_e        op_nxt;
    logic       alu7_nxt;
    logic       ill_nxt;

    assign word = {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5};

    always_comb begin
        op_nxt   = OP_ILL;
        alu7_nxt = 1'b0;
        ill_nxt  = 1'b0;
        case (word)
            6'b000000: op_nxt = OP_MOV;
            6'b000110: op_nxt = OP_AND;
            6'b001010: op_nxt = OP_OR;
            6'b001100: op_nxt = OP_NOT;
            6'b001110: op_nxt = OP_XOR;
            6'b010010: op_nxt = OP_ADD;
            // Subtract is A + ~B + 1; increment is A + 0 + 1.
            6'b010001: begin
                op_nxt   = OP_SUB;
                alu7_nxt = 1'b1;
            end
            6'b011011: begin
                op_nxt   = OP_INC;
                alu7_nxt = 1'b1;
            end
            // Decrement adds all-ones, so no carry-in.
            6'b011000: op_nxt = OP_DEC;
            6'b100000: op_nxt = OP_SLL;
            6'b100100: op_nxt = OP_SLA;
            // Rotates go through carry: the fill bit is the carry flag.
            6'b100010: begin
                op_nxt   = OP_ROL;
                alu7_nxt = c_flag;
            end
            6'b101000: op_nxt = OP_SRL;
            // Sign replication for SRA happens in the datapath.
            6'b101100: op_nxt = OP_SRA;
            6'b101010: begin
                op_nxt   = OP_ROR;
                alu7_nxt = c_flag;
            end
            default: begin
                op_nxt  = OP_ILL;
                ill_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU7_out <= 1'b0;
            op_idx   <= OP_ILL;
            illegal  <= 1'b0;
        end else begin
            ALU7_out <= alu7_nxt;
            op_idx   <= op_nxt;
            illegal  <= ill_nxt;
        end
    end

endmodule

// File: tb/tb_decode_alu7.sv
module tb_decode_alu7;

    logic       clk;
    logic       rst;
    logic       Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5;
    logic       c_flag;
    logic       ALU7_out;
    logic [3:0] op_idx;
    logic       illegal;

    int errors;
    int checks;

    typedef struct {
        string      name;
        logic [5:0] word;
        logic       c;
        logic [3:0] idx;
        logic       alu7;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    decode_alu7 dut (
        .clk      (clk),
        .rst      (rst),
        .Ctrl0    (Ctrl0),
        .Ctrl1    (Ctrl1),
        .Ctrl2    (Ctrl2),
        .Ctrl3    (Ctrl3),
        .Ctrl4    (Ctrl4),
        .Ctrl5    (Ctrl5),
        .c_flag   (c_flag),
        .ALU7_out (ALU7_out),
        .op_idx   (op_idx),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] w, input logic c);
        {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5} = w;
        c_flag = c;
    endtask

    task automatic check(input string name, input logic [3:0] idx,
                         input logic alu7, input logic ill);
        checks++;
        if (op_idx !== idx || ALU7_out !== alu7 || illegal !== ill) begin
            errors++;
            $display("FAIL %s: got idx=%0d alu7=%b ill=%b, expected idx=%0d alu7=%b ill=%b",
                     name, op_idx, ALU7_out, illegal, idx, alu7, ill);
        end
    endtask

    // Drive inputs, take one clock edge, sample just after it.
    task automatic step(input logic [5:0] w, input logic c);
        drive(w, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(6'b010001, 1'b0);

        // Table sweep with c_flag = 0
        vecs.push_back('{"MOV", 6'b000000, 1'b0, 4'd0,  1'b0, 1'b0});
        vecs.push_back('{"AND", 6'b000110, 1'b0, 4'd1,  1'b0, 1'b0});
        vecs.push_back('{"OR",  6'b001010, 1'b0, 4'd2,  1'b0, 1'b0});
        vecs.push_back('{"NOT", 6'b001100, 1'b0, 4'd3,  1'b0, 1'b0});
        vecs.push_back('{"XOR", 6'b001110, 1'b0, 4'd4,  1'b0, 1'b0});
        vecs.push_back('{"ADD", 6'b010010, 1'b0, 4'd5,  1'b0, 1'b0});
        vecs.push_back('{"SUB", 6'b010001, 1'b0, 4'd6,  1'b1, 1'b0});
        vecs.push_back('{"INC", 6'b011011, 1'b0, 4'd7,  1'b1, 1'b0});
        vecs.push_back('{"DEC", 6'b011000, 1'b0, 4'd8,  1'b0, 1'b0});
        vecs.push_back('{"SLL", 6'b100000, 1'b0, 4'd9,  1'b0, 1'b0});
        vecs.push_back('{"SLA", 6'b100100, 1'b0, 4'd10, 1'b0, 1'b0});
        vecs.push_back('{"ROL", 6'b100010, 1'b0, 4'd11, 1'b0, 1'b0});
        vecs.push_back('{"SRL", 6'b101000, 1'b0, 4'd12, 1'b0, 1'b0});
        vecs.push_back('{"SRA", 6'b101100, 1'b0, 4'd13, 1'b0, 1'b0});
        vecs.push_back('{"ROR", 6'b101010, 1'b0, 4'd14, 1'b0, 1'b0});
        // Rotates through carry, then carry drops
        vecs.push_back('{"ROL_c1", 6'b100010, 1'b1, 4'd11, 1'b1, 1'b0});
        vecs.push_back('{"ROL_c0", 6'b100010, 1'b0, 4'd11, 1'b0, 1'b0});
        vecs.push_back('{"ROR_c1", 6'b101010, 1'b1, 4'd14, 1'b1, 1'b0});
        vecs.push_back('{"ROR_c0", 6'b101010, 1'b0, 4'd14, 1'b0, 1'b0});
        // c_flag toggling must not disturb non-rotate words
        vecs.push_back('{"MOV_c1", 6'b000000, 1'b1, 4'd0,  1'b0, 1'b0});
        vecs.push_back('{"MOV_c0", 6'b000000, 1'b0, 4'd0,  1'b0, 1'b0});
        vecs.push_back('{"ADD_c1", 6'b010010, 1'b1, 4'd5,  1'b0, 1'b0});
        vecs.push_back('{"ADD_c0", 6'b010010, 1'b0, 4'd5,  1'b0, 1'b0});
        vecs.push_back('{"SRA_c1", 6'b101100, 1'b1, 4'd13, 1'b0, 1'b0});
        vecs.push_back('{"SRA_c0", 6'b101100, 1'b0, 4'd13, 1'b0, 1'b0});
        vecs.push_back('{"SUB_c1", 6'b010001, 1'b1, 4'd6,  1'b1, 1'b0});
        // Illegal words
        vecs.push_back('{"ILL_111111", 6'b111111, 1'b1, 4'd15, 1'b0, 1'b1});
        vecs.push_back('{"ILL_010000", 6'b010000, 1'b1, 4'd15, 1'b0, 1'b1});
        vecs.push_back('{"ILL_000001", 6'b000001, 1'b0, 4'd15, 1'b0, 1'b1});
        vecs.push_back('{"ILL_110010", 6'b110010, 1'b1, 4'd15, 1'b0, 1'b1});
        vecs.push_back('{"ILL_100011", 6'b100011, 1'b1, 4'd15, 1'b0, 1'b1});

        // Reset held two cycles with SUB on the inputs
        step(6'b010001, 1'b0);
        check("reset_cycle1", 4'd15, 1'b0, 1'b0);
        step(6'b010001, 1'b1);
        check("reset_cycle2", 4'd15, 1'b0, 1'b0);

        // Release: first edge registers the word then present
        rst = 1'b0;
        foreach (vecs[i]) begin
            step(vecs[i].word, vecs[i].c);
            check(vecs[i].name, vecs[i].idx, vecs[i].alu7, vecs[i].ill);
        end

        // Reset in the middle of an INC stream
        step(6'b011011, 1'b0);
        check("inc_stream", 4'd7, 1'b1, 1'b0);
        rst = 1'b1;
        step(6'b011011, 1'b0);
        check("inc_reset", 4'd15, 1'b0, 1'b0);
        rst = 1'b0;
        step(6'b011011, 1'b0);
        check("inc_after_reset", 4'd7, 1'b1, 1'b0);

        // Illegal flag clears on the next legal word
        step(6'b111111, 1'b0);
        check("ill_again", 4'd15, 1'b0, 1'b1);
        step(6'b011000, 1'b1);
        check("dec_after_ill", 4'd8, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
